ramdelay_ctrl: RTL

- Sequencing controller for a RAM-backed fixed delay line. It owns the read/write address generation, write pipelining, priming and the ready/valid handshake for an external simple dual-port synchronous-read RAM (iCE40 EBR style).
- Each accepted input sample produces exactly one output sample, equal to the input accepted CycleDelay transfers earlier.
- Sits between an upstream streaming source and a downstream DSP stage; the RAM itself is instantiated beside it.

---
 rtl/ramdelay_pkg.sv | 15 +
 rtl/ramdelay_ptr.sv | 42 ++++
 rtl/ramdelay_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/ramdelay_pkg.sv
// Shared types and helpers for the RAM-backed delay line controller.
package ramdelay_pkg;

  // INIT only exists when the RAM clear sweep is built in; RUN is normal streaming.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Next value of a counter that wraps at an arbitrary (non power-of-two) depth.
  function automatic logic [31:0] wrap_inc(input logic [31:0] cur, input logic [31:0] depth);
    return (cur == depth - 32'd1) ? 32'd0 : cur + 32'd1;
  endfunction

endpackage

// File: rtl/ramdelay_ptr.sv
// Modulo-Depth counter with synchronous clear; used for the delay-line pointer
// and for the address sweep that clears the RAM after reset.
module ramdelay_ptr
  import ramdelay_pkg::*;
#(
  parameter int Depth = 8,
  parameter int Width = 3
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o,
  output logic             last_o
);

  logic [Width-1:0] cnt_q;
  logic [Width-1:0] cnt_d;

  // Clear has priority over increment; increment wraps at Depth-1.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = Width'(wrap_inc(32'(cnt_q), 32'(Depth)));
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == Width'(Depth - 1));

endmodule

// File: rtl/ramdelay_ctrl.sv
// Sequencing controller for a RAM-backed fixed delay line (external simple
// dual-port, synchronous-read RAM). One output per accepted input, equal to the
// input accepted CycleDelay transfers earlier; first CycleDelay outputs after
// reset/flush are forced to zero.
// Optional macro RAMDELAY_CLEAR_EN: after reset the RAM is swept to zero in an
// INIT state, after which outputs come straight from the RAM (no zero masking).
module ramdelay_ctrl
  import ramdelay_pkg::*;
#(
  parameter  int DataWidth  = 8,
  parameter  int CycleDelay = 8,
  localparam int AddrWidth  = $clog2(CycleDelay)
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 flush_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic                 valid_o,
  output logic [DataWidth-1:0] data_o,
  input  logic                 ready_i,
  output logic                 ram_wr_en_o,
  output logic [AddrWidth-1:0] ram_wr_addr_o,
  output logic [DataWidth-1:0] ram_wdata_o,
  output logic                 ram_rd_en_o,
  output logic [AddrWidth-1:0] ram_rd_addr_o,
  input  logic [DataWidth-1:0] ram_rdata_i,
  output logic                 primed_o
);

  if (CycleDelay < 2 || CycleDelay > 4096) begin : g_bad_depth
    $error("ramdelay_ctrl: CycleDelay must be in 2..4096");
  end

`ifdef RAMDELAY_CLEAR_EN
  localparam bit KeepPrimedOnFlush = 1'b1;
`else
  localparam bit KeepPrimedOnFlush = 1'b0;
`endif

  logic                 accept;
  logic                 run;
  logic                 init_done;
  logic [AddrWidth-1:0] ptr;
  logic                 ptr_last;

  logic                 valid_q;
  logic                 primed_q;
  logic                 zero_q;
  logic                 wr_en_q;
  logic [AddrWidth-1:0] wr_addr_q;
  logic [DataWidth-1:0] wdata_q;

  // Upstream may only push when the output slot is free or draining this cycle.
  assign ready_o = reset_ni && run && !flush_i && (!valid_q || ready_i);
  assign accept  = valid_i && ready_o;

  // Delay-line pointer; until primed it also serves as the priming count,
  // since both start at zero after reset/flush and advance per accept.
  ramdelay_ptr #(
    .Depth (CycleDelay),
    .Width (AddrWidth)
  ) u_ptr (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .clear_i  (flush_i),
    .inc_i    (accept),
    .cnt_o    (ptr),
    .last_o   (ptr_last)
  );

  // ---- stage 0: accept cycle issues the read of the oldest slot ----
  assign ram_rd_en_o   = accept;
  assign ram_rd_addr_o = ptr;

  // Output valid: set on accept, cleared on downstream transfer; flush wins.
  always_ff @(posedge clk_i) begin
    if (!reset_ni || flush_i) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  // Delayed write strobe/address so the write lands one cycle after the read.
  always_ff @(posedge clk_i) begin
    if (!reset_ni || flush_i) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      wr_en_q <= accept;
      if (accept) begin
        wr_addr_q <= ptr;
      end
    end
  end

  // Write data register (datapath, no reset needed).
  always_ff @(posedge clk_i) begin
    if (accept) begin
      wdata_q <= data_i;
    end
  end

  // Priming flag and per-sample zero mask captured at accept time.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      primed_q <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      if (init_done) begin
        primed_q <= 1'b1;
      end else if (flush_i) begin
        primed_q <= KeepPrimedOnFlush & primed_q;
      end else if (accept && ptr_last) begin
        primed_q <= 1'b1;
      end
      if (accept) begin
        zero_q <= !primed_q;
      end
    end
  end

  // ---- stage 1: RAM read data arrives; write of the previous sample ----
  assign valid_o  = valid_q;
  assign primed_o = primed_q;
  assign data_o   = zero_q ? '0 : ram_rdata_i;

`ifdef RAMDELAY_CLEAR_EN
  state_e               state_q;
  state_e               state_d;
  logic                 in_init;
  logic [AddrWidth-1:0] sweep;
  logic                 sweep_last;

  assign in_init = (state_q == ST_INIT) && reset_ni;
  assign run     = (state_q == ST_RUN);

  // Sweep address for zeroing the RAM; wraps back to 0 when finished.
  ramdelay_ptr #(
    .Depth (CycleDelay),
    .Width (AddrWidth)
  ) u_sweep (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .clear_i  (1'b0),
    .inc_i    (in_init),
    .cnt_o    (sweep),
    .last_o   (sweep_last)
  );

  // State register; reset always restarts the clear sweep.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Leave INIT once the last address has been written this cycle.
  always_comb begin
    state_d   = state_q;
    init_done = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (sweep_last) begin
          state_d   = ST_RUN;
          init_done = 1'b1;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  assign ram_wr_en_o   = in_init || wr_en_q;
  assign ram_wr_addr_o = in_init ? sweep : wr_addr_q;
  assign ram_wdata_o   = in_init ? '0 : wdata_q;
`else
  assign run           = 1'b1;
  assign init_done     = 1'b0;
  assign ram_wr_en_o   = wr_en_q;
  assign ram_wr_addr_o = wr_addr_q;
  assign ram_wdata_o   = wdata_q;
`endif

endmodule
